nand_cmd_addr_seq: RTL and testbench
====================================

Name: nand_cmd_addr_seq

Overview:
Parametrised NAND flash command/address latch sequencer. Replaces the fixed read-only, 4-address-byte latch block.
- Issues an optional first command byte, 0..ADDR_CYCLES address bytes and an optional second command byte.
- WE# low and high widths are programmable.
- Uses a start/busy/done handshake and can hold CE# low afterwards.
- Sits between the flash controller FSM and the NAND pad ring. The IO bus is split into out/oe; the tristate lives at the top level.

Parameters:
- IO_W, 8, NAND IO bus width (8 or 16). Command and address bytes are zero-extended into it.
- ADDR_CYCLES, 5, maximum address bytes per operation (1..8).
- WE_LOW_CYC, 2, clk cycles WE# is held low per byte (>=1).
- WE_HIGH_CYC, 2, clk cycles WE# is held high after each rising edge, data held (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request. Accepted only when busy=0.
- use_cmd1  in  1  issue cmd1 first.
- cmd1  in  8  first command byte (e.g. 8'h00, 8'h80, 8'h60).
- addr_cycles  in  4  address byte count. Values above ADDR_CYCLES clamp to ADDR_CYCLES.
- addr  in  8*ADDR_CYCLES  address bytes. Byte 0 = addr[7:0] is sent first.
- use_cmd2  in  1  issue cmd2 after the address bytes.
- cmd2  in  8  second command byte (e.g. 8'h30, 8'hD0).
- keep_ce  in  1  leave ce_n low after completion.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- ce_n  out  1  chip enable, active low.
- cle  out  1  command latch enable.
- ale  out  1  address latch enable.
- we_n  out  1  write enable, active low.
- io_out  out  IO_W  NAND IO drive value.
- io_oe  out  1  IO output enable.

Behaviour:
- Reset (async, immediate): ce_n=1, we_n=1, cle=0, ale=0, io_out=0, io_oe=0, busy=0, done=0. State IDLE, all counters 0. Reset mid-operation aborts with no further we_n edges.
- Capture: on the edge where start=1 and busy=0, all inputs are registered (use_cmd1/2, cmd1/2, addr, addr_cycles clamped, keep_ce). Later input changes have no effect until the next start. start while busy=1 is ignored.
- Byte count: N = use_cmd1 + addr_cycles_eff + use_cmd2. Byte order: cmd1, addr byte 0..addr_cycles_eff-1, cmd2.
- States: IDLE -> (SETUP -> WE_LO -> WE_HI) per byte -> FINISH -> IDLE.
  - N=0 goes IDLE -> FINISH directly.
- Byte phase, B = 1 + WE_LOW_CYC + WE_HIGH_CYC cycles:
  - SETUP (1 cycle): ce_n=0; cle=1 for command bytes, ale=1 for address bytes, never both. io_out=byte; io_oe=1; we_n=1.
  - WE_LO (WE_LOW_CYC cycles): we_n=0, everything else held.
  - WE_HI (WE_HIGH_CYC cycles): we_n=1, cle/ale/io held.
  - Byte/phase counters advance at the end of WE_HI. The next byte's SETUP updates cle/ale/io.
- FINISH (1 cycle): cle=0, ale=0, io_oe=0, io_out=0, we_n=1, busy=1. ce_n = ~keep_ce_reg... ce_n=1 if keep_ce_reg=0, else 0.
- Timing: start sampled in cycle 0. busy=1 in cycles 1..N*B+1. Cycle N*B+2: IDLE, busy=0, done=1 for exactly one cycle.
- A new start may be accepted in the done cycle.
- ce_n in IDLE keeps its FINISH value. It goes high only at the FINISH of an operation with keep_ce=0, or at reset.
- Counters sized $clog2(max(WE_LOW_CYC, WE_HIGH_CYC)+1) and $clog2(ADDR_CYCLES+3).
- Upper IO bits are 0 when IO_W=16.

Test Plan:
- Page read (defaults): cmd1=00, addr_cycles=5, addr=40'h0403020100, cmd2=30, keep_ce=0.
  -> 7 we_n low pulses of 2 cycles each, with io = 00,00,01,02,03,04,30.
  -> cle=1 on bytes 1 and 7; ale=1 on bytes 2-6.
  -> done pulse at cycle 37; ce_n high from cycle 36.
- Address-only: use_cmd1=0, use_cmd2=0, addr_cycles=3. -> 3 ale pulses, cle never high, done at cycle 17.
- N=0 request. -> no we_n edge; done at cycle 2; busy high in cycle 1 only.
- addr_cycles=9 with ADDR_CYCLES=5. -> exactly 5 address bytes.
- start pulsed and cmd2 changed mid-operation. -> ignored; original cmd2 is sent.
- keep_ce=1 then keep_ce=0: first operation leaves ce_n=0 through IDLE; second operation drives ce_n=1 at its FINISH.
- rst asserted during the 3rd address byte's WE_LO. -> all outputs return to reset values in that cycle; no done pulse.

Source files
------------

// File: rtl/nand_cmd_addr_seq.sv
// NAND command/address latch sequencer: optional cmd1, 0..ADDR_CYCLES address
// bytes, optional cmd2, with programmable WE# low/high widths and CE# hold.
//
// state     | meaning
// ST_IDLE   | waiting for start; ce_n holds last FINISH value
// ST_SETUP  | ce_n low, cle/ale and io set up for the current byte, we_n high
// ST_WE_LO  | we_n low for WE_LOW_CYC cycles
// ST_WE_HI  | we_n high for WE_HIGH_CYC cycles, byte held; advances byte index
// ST_FINISH | bus released, ce_n per keep_ce; done follows in IDLE
module nand_cmd_addr_seq #(
  parameter int IO_W        = 8,
  parameter int ADDR_CYCLES = 5,
  parameter int WE_LOW_CYC  = 2,
  parameter int WE_HIGH_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     use_cmd1,
  input  logic [7:0]               cmd1,
  input  logic [3:0]               addr_cycles,
  input  logic [8*ADDR_CYCLES-1:0] addr,
  input  logic                     use_cmd2,
  input  logic [7:0]               cmd2,
  input  logic                     keep_ce,
  output logic                     busy,
  output logic                     done,
  output logic                     ce_n,
  output logic                     cle,
  output logic                     ale,
  output logic                     we_n,
  output logic [IO_W-1:0]          io_out,
  output logic                     io_oe
);

  localparam int PH_MAX = (WE_LOW_CYC > WE_HIGH_CYC) ? WE_LOW_CYC : WE_HIGH_CYC;
  localparam int CNT_W  = $clog2(PH_MAX + 1);
  localparam int BYTE_W = $clog2(ADDR_CYCLES + 3);
  localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(WE_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(WE_HIGH_CYC - 1);
  localparam logic [3:0]       AC_MAX  = 4'(ADDR_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_WE_LO, ST_WE_HI, ST_FINISH
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BYTE_W-1:0]        byte_q, byte_d;
  logic [BYTE_W-1:0]        n_q, n_d;
  logic [3:0]               ac_q, ac_d;
  logic                     use_cmd1_q, use_cmd1_d;
  logic                     use_cmd2_q, use_cmd2_d;
  logic [7:0]               cmd1_q, cmd1_d;
  logic [7:0]               cmd2_q, cmd2_d;
  logic [8*ADDR_CYCLES-1:0] addr_q, addr_d;
  logic                     keep_ce_q, keep_ce_d;
  logic                     ce_hold_q, ce_hold_d;
  logic                     done_q, done_d;

  logic [3:0]               ac_eff;
  logic [BYTE_W-1:0]        n_req;
  logic [BYTE_W-1:0]        addr_idx;
  logic [7:0]               addr_byte;
  logic                     is_cmd1, is_cmd2;
  logic [7:0]               byte_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      byte_q     <= '0;
      n_q        <= '0;
      ac_q       <= '0;
      use_cmd1_q <= 1'b0;
      use_cmd2_q <= 1'b0;
      cmd1_q     <= '0;
      cmd2_q     <= '0;
      addr_q     <= '0;
      keep_ce_q  <= 1'b0;
      ce_hold_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      n_q        <= n_d;
      ac_q       <= ac_d;
      use_cmd1_q <= use_cmd1_d;
      use_cmd2_q <= use_cmd2_d;
      cmd1_q     <= cmd1_d;
      cmd2_q     <= cmd2_d;
      addr_q     <= addr_d;
      keep_ce_q  <= keep_ce_d;
      ce_hold_q  <= ce_hold_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    ac_eff     = (addr_cycles > AC_MAX) ? AC_MAX : addr_cycles;
    n_req      = BYTE_W'(ac_eff) + BYTE_W'(use_cmd1) + BYTE_W'(use_cmd2);
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    n_d        = n_q;
    ac_d       = ac_q;
    use_cmd1_d = use_cmd1_q;
    use_cmd2_d = use_cmd2_q;
    cmd1_d     = cmd1_q;
    cmd2_d     = cmd2_q;
    addr_d     = addr_q;
    keep_ce_d  = keep_ce_q;
    ce_hold_d  = ce_hold_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          use_cmd1_d = use_cmd1;
          use_cmd2_d = use_cmd2;
          cmd1_d     = cmd1;
          cmd2_d     = cmd2;
          addr_d     = addr;
          ac_d       = ac_eff;
          keep_ce_d  = keep_ce;
          n_d        = n_req;
          byte_d     = '0;
          state_d    = (n_req == '0) ? ST_FINISH : ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_WE_LO;
        cnt_d   = LO_LOAD;
      end
      ST_WE_LO: begin
        if (cnt_q == '0) begin
          state_d = ST_WE_HI;
          cnt_d   = HI_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WE_HI: begin
        if (cnt_q == '0) begin
          if (byte_q == n_q - 1'b1) begin
            state_d = ST_FINISH;
            byte_d  = '0;
          end else begin
            state_d = ST_SETUP;
            byte_d  = byte_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FINISH: begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        ce_hold_d = ~keep_ce_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte order is cmd1, address bytes 0..ac-1, cmd2; index is relative to that list.
  always_comb begin
    addr_idx  = byte_q - BYTE_W'(use_cmd1_q);
    addr_byte = '0;
    for (int i = 0; i < ADDR_CYCLES; i++) begin
      if (addr_idx == BYTE_W'(i)) addr_byte = addr_q[i*8 +: 8];
    end
    is_cmd1  = use_cmd1_q && (byte_q == '0);
    is_cmd2  = use_cmd2_q && (byte_q == BYTE_W'(ac_q) + BYTE_W'(use_cmd1_q));
    byte_val = is_cmd1 ? cmd1_q : (is_cmd2 ? cmd2_q : addr_byte);
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    done   = done_q;
    ce_n   = ce_hold_q;
    cle    = 1'b0;
    ale    = 1'b0;
    we_n   = 1'b1;
    io_out = '0;
    io_oe  = 1'b0;
    case (state_q)
      ST_SETUP, ST_WE_LO, ST_WE_HI: begin
        ce_n   = 1'b0;
        cle    = is_cmd1 | is_cmd2;
        ale    = ~(is_cmd1 | is_cmd2);
        io_out = IO_W'(byte_val);
        io_oe  = 1'b1;
        we_n   = (state_q != ST_WE_LO);
      end
      ST_FINISH: ce_n = ~keep_ce_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nand_cmd_addr_seq.sv
// Randomized bench for nand_cmd_addr_seq against a byte-list reference model.
module tb_nand_cmd_addr_seq;
  localparam int IO_W = 8;
  localparam int AC   = 5;
  localparam int WL   = 2;
  localparam int WH   = 2;
  localparam int B    = 1 + WL + WH;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, use_cmd1, use_cmd2, keep_ce;
  logic [7:0]      cmd1, cmd2;
  logic [3:0]      addr_cycles;
  logic [8*AC-1:0] addr;
  logic            busy, done, ce_n, cle, ale, we_n, io_oe;
  logic [IO_W-1:0] io_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nand_cmd_addr_seq #(.IO_W(IO_W), .ADDR_CYCLES(AC), .WE_LOW_CYC(WL), .WE_HIGH_CYC(WH)) dut (
    .clk(clk), .rst(rst), .start(start), .use_cmd1(use_cmd1), .cmd1(cmd1),
    .addr_cycles(addr_cycles), .addr(addr), .use_cmd2(use_cmd2), .cmd2(cmd2),
    .keep_ce(keep_ce), .busy(busy), .done(done), .ce_n(ce_n), .cle(cle),
    .ale(ale), .we_n(we_n), .io_out(io_out), .io_oe(io_oe)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string where);
    chk({where, "_ce_n"},   64'(ce_n),   64'd1);
    chk({where, "_we_n"},   64'(we_n),   64'd1);
    chk({where, "_cle"},    64'(cle),    64'd0);
    chk({where, "_ale"},    64'(ale),    64'd0);
    chk({where, "_io_out"}, 64'(io_out), 64'd0);
    chk({where, "_io_oe"},  64'(io_oe),  64'd0);
    chk({where, "_busy"},   64'(busy),   64'd0);
    chk({where, "_done"},   64'(done),   64'd0);
  endtask

  task automatic idle(input int k, input bit exp_ce);
    repeat (k) begin
      @(negedge clk);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_ce_n", 64'(ce_n), 64'(exp_ce));
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (or after an abort).
  task automatic run_op(input bit u1, input logic [7:0] c1, input logic [3:0] ac,
                        input logic [8*AC-1:0] a, input bit u2, input logic [7:0] c2,
                        input bit kc, input int abort_at, input bit perturb);
    logic [8:0] exp_q[$];
    int n, ac_eff, cyc, done_cyc, busy_cnt, lo_len, pulses, both_hi, bad;
    logic prev_we;
    ac_eff = (int'(ac) > AC) ? AC : int'(ac);
    if (u1) exp_q.push_back({1'b1, c1});
    for (int i = 0; i < ac_eff; i++) exp_q.push_back({1'b0, a[i*8 +: 8]});
    if (u2) exp_q.push_back({1'b1, c2});
    n = exp_q.size();

    start = 1'b1; use_cmd1 = u1; cmd1 = c1; addr_cycles = ac; addr = a;
    use_cmd2 = u2; cmd2 = c2; keep_ce = kc;
    cyc = 0; done_cyc = -1; busy_cnt = 0; lo_len = 0; pulses = 0; both_hi = 0;
    prev_we = 1'b1;
    while (done_cyc < 0 && cyc < n*B + 10) begin
      @(negedge clk);
      cyc++;
      if (abort_at != 0 && cyc == abort_at) begin
        chk("abort_in_we_lo", 64'(we_n), 64'd0);
        rst = 1'b1;
        start = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 3*B; k++) begin
          @(negedge clk);
          if (done || busy || !we_n || !ce_n) bad++;
        end
        chk("abort_quiet", 64'(bad), 64'd0);
        return;
      end
      if (busy) busy_cnt++;
      if (done) done_cyc = cyc;
      if (cle && ale) both_hi++;
      if (!we_n) lo_len++;
      if (we_n && !prev_we) begin
        chk("we_rise_cycle", 64'(cyc), 64'(2 + pulses*B + WL));
        chk("we_low_width", 64'(lo_len), 64'(WL));
        if (pulses < n) begin
          chk("byte_io", 64'(io_out), 64'(exp_q[pulses][7:0]));
          chk("byte_cle", 64'(cle), 64'(exp_q[pulses][8]));
          chk("byte_ale", 64'(ale), 64'(!exp_q[pulses][8]));
          chk("byte_oe_ce", 64'({io_oe, ce_n}), 64'b10);
        end
        pulses++;
        lo_len = 0;
      end
      if (cyc == n*B + 1) begin
        chk("finish_ce_n", 64'(ce_n), 64'(!kc));
        chk("finish_bus", 64'({cle, ale, io_oe, we_n, busy}), 64'b00011);
      end
      prev_we = we_n;
      if (perturb) begin
        cmd1 = 8'($urandom); cmd2 = 8'($urandom); addr = 40'({$urandom, $urandom});
        addr_cycles = 4'($urandom); use_cmd1 = 1'($urandom); use_cmd2 = 1'($urandom);
        keep_ce = 1'($urandom);
        start = (cyc < n*B + 1) && ($urandom_range(0, 2) == 0);
      end else begin
        start = 1'b0;
      end
    end
    chk("we_pulse_count", 64'(pulses), 64'(n));
    chk("done_cycle", 64'(done_cyc), 64'(n*B + 2));
    chk("busy_cycles", 64'(busy_cnt), 64'(n*B + 1));
    chk("cle_ale_both", 64'(both_hi), 64'd0);
    if (done_cyc >= 0) chk("done_ce_n", 64'(ce_n), 64'(!kc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit u1, u2, kc, pert;
    rst = 1'b1; start = 1'b0; use_cmd1 = 1'b0; use_cmd2 = 1'b0; keep_ce = 1'b0;
    cmd1 = '0; cmd2 = '0; addr_cycles = '0; addr = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b1, 8'h00, 4'd5, 40'h0403020100, 1'b1, 8'h30, 1'b0, 0, 1'b0);
    idle(2, 1'b1);
    run_op(1'b0, 8'h00, 4'd3, 40'({$urandom, $urandom}), 1'b0, 8'h30, 1'b0, 0, 1'b0);
    idle(2, 1'b1);
    run_op(1'b0, 8'h00, 4'd0, 40'h0, 1'b0, 8'h30, 1'b0, 0, 1'b0);
    idle(2, 1'b1);
    run_op(1'b1, 8'h60, 4'd9, 40'h99AABBCCDD, 1'b1, 8'hD0, 1'b0, 0, 1'b0);
    idle(1, 1'b1);
    run_op(1'b1, 8'h00, 4'd5, 40'h0403020100, 1'b1, 8'h30, 1'b0, 0, 1'b1);
    idle(2, 1'b1);
    run_op(1'b1, 8'h80, 4'd2, 40'h000000BEEF, 1'b0, 8'h10, 1'b1, 0, 1'b0);
    idle(3, 1'b0);
    run_op(1'b1, 8'h80, 4'd1, 40'h0000000042, 1'b0, 8'h10, 1'b1, 0, 1'b0);
    run_op(1'b1, 8'h00, 4'd4, 40'h0011223344, 1'b1, 8'h30, 1'b0, 0, 1'b0);
    idle(2, 1'b1);

    for (int r = 0; r < 24; r++) begin
      u1 = 1'($urandom); u2 = 1'($urandom); kc = 1'($urandom); pert = 1'($urandom);
      run_op(u1, 8'($urandom), 4'($urandom_range(0, 11)), 40'({$urandom, $urandom}),
             u2, 8'($urandom), kc, 0, pert);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), !kc);
    end
    idle(1, !kc);

    run_op(1'b1, 8'h00, 4'd5, 40'h0403020100, 1'b1, 8'h30, 1'b0, 1 + 3*B + 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
